// File: rtl/ff_regfile_pkg.sv
// ff_regfile_pkg: shared definitions for the multi-port valid-tracked
// flip-flop register file.
//   clog2_cnt  - width of a counter that must hold 0..depth inclusive
//   rd_rsp_t   - one read-port response {data, valid, err} at the default
//                entry width RSP_DATA_W
package ff_regfile_pkg;

  localparam int RSP_DATA_W = 8;

  typedef struct packed {
    logic [RSP_DATA_W-1:0] data;
    logic                  valid;
    logic                  err;
  } rd_rsp_t;

  // The occupancy count must represent DEPTH itself, hence depth+1.
  function automatic int clog2_cnt(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/ff_regfile_rd_port.sv
// ff_regfile_rd_port: one registered read port of ff_regfile_mp.
//   clk, resetn     - clock, synchronous active-low reset
//   mem_i, valid_i  - current entry array and valid vector (pre-edge state)
//   byp_en_i/addr_i/data_i - same-cycle in-range write, for write-through
//   rd_en_i, rd_addr_i     - read request
//   rd_data_o, rd_valid_o, rd_err_o - response, one cycle after rd_en_i
// Handshake: a request is accepted whenever rd_en_i is high at a rising
// edge (no ready); the response is a single-cycle strobe on rd_valid_o, and
// rd_data_o/rd_err_o are zero whenever rd_valid_o is low.
module ff_regfile_rd_port #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3,
  parameter int DEPTH  = 8,
  parameter int BYPASS = 1
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic [DEPTH-1:0][DATA_W-1:0] mem_i,
  input  logic [DEPTH-1:0]             valid_i,
  input  logic                         byp_en_i,
  input  logic [ADDR_W-1:0]            byp_addr_i,
  input  logic [DATA_W-1:0]            byp_data_i,
  input  logic                         rd_en_i,
  input  logic [ADDR_W-1:0]            rd_addr_i,
  output logic [DATA_W-1:0]            rd_data_o,
  output logic                         rd_valid_o,
  output logic                         rd_err_o
);

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  logic              in_range;
  logic              byp_hit;
  logic              sel_valid;
  logic [DATA_W-1:0] sel_data;
  logic [DATA_W-1:0] data_d, data_q;
  logic              valid_d, valid_q;
  logic              err_d, err_q;

  assign in_range = ({1'b0, rd_addr_i} < DEPTH_L);
  assign byp_hit  = (BYPASS != 0) && byp_en_i && (byp_addr_i == rd_addr_i);

  // Decoded select keeps the array index within 0..DEPTH-1 even when
  // rd_addr_i is out of range.
  always_comb begin
    sel_valid = 1'b0;
    sel_data  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (rd_addr_i == ADDR_W'(i)) begin
        sel_valid = valid_i[i];
        sel_data  = mem_i[i];
      end
    end
  end

  always_comb begin
    data_d  = '0;
    valid_d = 1'b0;
    err_d   = 1'b0;
    if (rd_en_i) begin
      valid_d = 1'b1;
      if (byp_hit) begin
        data_d = byp_data_i;
      end else if (in_range && sel_valid) begin
        data_d = sel_data;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign rd_data_o  = data_q;
  assign rd_valid_o = valid_q;
  assign rd_err_o   = err_q;

endmodule

// File: rtl/ff_regfile_mp.sv
// ff_regfile_mp: flip-flop register file with per-entry valid bits, one
// write port, an invalidate port, a global flush and RD_PORTS registered
// read ports.
//   clk, resetn        - clock, synchronous active-low reset
//   wr_en/addr/data    - write; sets the entry valid
//   inv_en/addr        - clear one valid bit, data retained
//   flush              - clear all valid bits
//   rd_en, rd_addr     - per-port read requests (packed, ADDR_W per port)
//   rd_data, rd_valid, rd_err - per-port responses (packed, DATA_W per port)
//   wr_err             - one-cycle pulse after an out-of-range write/invalidate
//   count              - number of valid entries
module ff_regfile_mp
  import ff_regfile_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 3,
  parameter int DEPTH    = 8,
  parameter int RD_PORTS = 2,
  parameter int BYPASS   = 1
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         wr_en,
  input  logic [ADDR_W-1:0]            wr_addr,
  input  logic [DATA_W-1:0]            wr_data,
  input  logic                         inv_en,
  input  logic [ADDR_W-1:0]            inv_addr,
  input  logic                         flush,
  input  logic [RD_PORTS-1:0]          rd_en,
  input  logic [RD_PORTS*ADDR_W-1:0]   rd_addr,
  output logic [RD_PORTS*DATA_W-1:0]   rd_data,
  output logic [RD_PORTS-1:0]          rd_valid,
  output logic [RD_PORTS-1:0]          rd_err,
  output logic                         wr_err,
  output logic [clog2_cnt(DEPTH)-1:0]  count
);

  localparam int              CNT_W   = clog2_cnt(DEPTH);
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  logic [DEPTH-1:0][DATA_W-1:0] mem_q;
  logic [DEPTH-1:0]             valid_d, valid_q;
  logic [CNT_W-1:0]             count_d, count_q;
  logic                         wr_err_d, wr_err_q;
  logic                         wr_ok, inv_ok;
  logic [DEPTH-1:0]             wr_dec, inv_dec;

  assign wr_ok  = wr_en  && ({1'b0, wr_addr}  < DEPTH_L);
  assign inv_ok = inv_en && ({1'b0, inv_addr} < DEPTH_L);

  always_comb begin
    wr_dec  = '0;
    inv_dec = '0;
    for (int i = 0; i < DEPTH; i++) begin
      wr_dec[i]  = wr_ok  && (wr_addr  == ADDR_W'(i));
      inv_dec[i] = inv_ok && (inv_addr == ADDR_W'(i));
    end
  end

  // Valid-bit priority: flush > write > invalidate. count is the popcount
  // of the next-state vector so it lines up with valid_q every cycle.
  always_comb begin
    valid_d = valid_q;
    count_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (inv_dec[i]) valid_d[i] = 1'b0;
      if (wr_dec[i])  valid_d[i] = 1'b1;
      if (flush)      valid_d[i] = 1'b0;
      count_d = count_d + CNT_W'(valid_d[i]);
    end
  end

  // Out-of-range write and invalidate in one cycle collapse into one pulse.
  assign wr_err_d = (wr_en && !wr_ok) || (inv_en && !inv_ok);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      valid_q  <= '0;
      count_q  <= '0;
      wr_err_q <= 1'b0;
    end else begin
      valid_q  <= valid_d;
      count_q  <= count_d;
      wr_err_q <= wr_err_d;
    end
  end

  // Data array is deliberately not reset; valid bits gate every read.
  // A write during flush still lands in the array.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (wr_dec[i]) mem_q[i] <= wr_data;
    end
  end

  for (genvar p = 0; p < RD_PORTS; p++) begin : g_rd
    ff_regfile_rd_port #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH),
      .BYPASS (BYPASS)
    ) u_rd (
      .clk        (clk),
      .resetn     (resetn),
      .mem_i      (mem_q),
      .valid_i    (valid_q),
      .byp_en_i   (wr_ok),
      .byp_addr_i (wr_addr),
      .byp_data_i (wr_data),
      .rd_en_i    (rd_en[p]),
      .rd_addr_i  (rd_addr[p*ADDR_W +: ADDR_W]),
      .rd_data_o  (rd_data[p*DATA_W +: DATA_W]),
      .rd_valid_o (rd_valid[p]),
      .rd_err_o   (rd_err[p])
    );
  end

  assign wr_err = wr_err_q;
  assign count  = count_q;

endmodule

// File: tb/tb_ff_regfile_mp.sv
// tb_ff_regfile_mp: directed bench for ff_regfile_mp. Three instances share
// one stimulus stream: BYPASS=1/DEPTH=8, BYPASS=0/DEPTH=8, BYPASS=1/DEPTH=6.
module tb_ff_regfile_mp;
  import ff_regfile_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [7:0]  wr_data;
  logic        inv_en;
  logic [2:0]  inv_addr;
  logic        flush;
  logic [1:0]  rd_en;
  logic [5:0]  rd_addr;

  logic [15:0] b1_rd_data, b0_rd_data, d6_rd_data;
  logic [1:0]  b1_rd_valid, b0_rd_valid, d6_rd_valid;
  logic [1:0]  b1_rd_err, b0_rd_err, d6_rd_err;
  logic        b1_wr_err, b0_wr_err, d6_wr_err;
  logic [3:0]  b1_count, b0_count;
  logic [2:0]  d6_count;

  ff_regfile_mp #(.DATA_W(8), .ADDR_W(3), .DEPTH(8), .RD_PORTS(2), .BYPASS(1)) u_b1 (
    .clk(clk), .resetn(resetn), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .inv_en(inv_en), .inv_addr(inv_addr), .flush(flush), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(b1_rd_data), .rd_valid(b1_rd_valid), .rd_err(b1_rd_err),
    .wr_err(b1_wr_err), .count(b1_count));

  ff_regfile_mp #(.DATA_W(8), .ADDR_W(3), .DEPTH(8), .RD_PORTS(2), .BYPASS(0)) u_b0 (
    .clk(clk), .resetn(resetn), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .inv_en(inv_en), .inv_addr(inv_addr), .flush(flush), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(b0_rd_data), .rd_valid(b0_rd_valid), .rd_err(b0_rd_err),
    .wr_err(b0_wr_err), .count(b0_count));

  ff_regfile_mp #(.DATA_W(8), .ADDR_W(3), .DEPTH(6), .RD_PORTS(2), .BYPASS(1)) u_d6 (
    .clk(clk), .resetn(resetn), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .inv_en(inv_en), .inv_addr(inv_addr), .flush(flush), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(d6_rd_data), .rd_valid(d6_rd_valid), .rd_err(d6_rd_err),
    .wr_err(d6_wr_err), .count(d6_count));

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare port p of the BYPASS=1/DEPTH=8 instance against a response.
  task automatic chk_b1_port(input string tag, input int p, input rd_rsp_t exp);
    chk({tag, "_data"},  32'(b1_rd_data[p*8 +: 8]), 32'(exp.data));
    chk({tag, "_valid"}, 32'(b1_rd_valid[p]),       32'(exp.valid));
    chk({tag, "_err"},   32'(b1_rd_err[p]),         32'(exp.err));
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle();
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    inv_en = 1'b0; inv_addr = '0; flush = 1'b0;
    rd_en = '0; rd_addr = '0;
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
  endtask

  task automatic rd(input int p, input logic [2:0] a);
    rd_en[p] = 1'b1;
    rd_addr[p*3 +: 3] = a;
  endtask

  // Advance one edge; outputs are sampled 1 ns later, away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rd_rsp_t e;
    idle();
    resetn = 1'b0;
    step();
    step();
    chk("rst_valid", 32'(b1_rd_valid), 32'h0);
    chk("rst_count", 32'(b1_count),    32'h0);
    chk("rst_wrerr", 32'(b1_wr_err),   32'h0);
    chk("rst_data",  32'(b1_rd_data),  32'h0);
    resetn = 1'b1;

    // Read of an unwritten entry.
    rd(0, 3'd3);
    step(); idle();
    e = '{data: 8'h00, valid: 1'b1, err: 1'b1};
    chk_b1_port("unwr_p0", 0, e);
    chk("unwr_p1_valid", 32'(b1_rd_valid[1]), 32'h0);
    chk("unwr_count", 32'(b1_count), 32'h0);

    // Write then read on both ports.
    wr(3'd2, 8'hA5);
    step(); idle();
    chk("wr2_count", 32'(b1_count), 32'h1);
    chk("wr2_novalid", 32'(b1_rd_valid), 32'h0);
    rd(0, 3'd2); rd(1, 3'd2);
    step(); idle();
    chk("rd2_data",  32'(b1_rd_data),  32'hA5A5);
    chk("rd2_err",   32'(b1_rd_err),   32'h0);
    chk("rd2_valid", 32'(b1_rd_valid), 32'h3);

    // Same-cycle write and read of addr 5: write-through vs pre-write state.
    wr(3'd5, 8'h3C); rd(0, 3'd5);
    step(); idle();
    e = '{data: 8'h3C, valid: 1'b1, err: 1'b0};
    chk_b1_port("byp1", 0, e);
    chk("byp0_data", 32'(b0_rd_data[7:0]), 32'h00);
    chk("byp0_err",  32'(b0_rd_err[0]),    32'h1);
    chk("byp1_count", 32'(b1_count), 32'h2);
    rd(0, 3'd5); rd(1, 3'd5);
    step(); idle();
    chk("after_b1_data", 32'(b1_rd_data), 32'h3C3C);
    chk("after_b0_data", 32'(b0_rd_data), 32'h3C3C);
    chk("after_b0_err",  32'(b0_rd_err),  32'h0);

    // Fill every entry with 0x10+i.
    for (int i = 0; i < 8; i++) begin
      wr(3'(i), 8'(8'h10 + i));
      step(); idle();
    end
    chk("fill_count", 32'(b1_count), 32'h8);
    chk("fill_d6_count", 32'(d6_count), 32'h6);

    // Invalidate addr 4 while reading it: read sees pre-clear state.
    inv_en = 1'b1; inv_addr = 3'd4; rd(0, 3'd4);
    step(); idle();
    e = '{data: 8'h14, valid: 1'b1, err: 1'b0};
    chk_b1_port("inv_rd", 0, e);
    chk("inv_count", 32'(b1_count), 32'h7);
    rd(1, 3'd4);
    step(); idle();
    e = '{data: 8'h00, valid: 1'b1, err: 1'b1};
    chk_b1_port("inv_after", 1, e);
    chk("inv_after_p0_valid", 32'(b1_rd_valid[0]), 32'h0);

    // Invalidating an already-invalid entry leaves count alone.
    inv_en = 1'b1; inv_addr = 3'd4;
    step(); idle();
    chk("reinv_count", 32'(b1_count), 32'h7);

    // Write plus flush: everything ends invalid.
    wr(3'd1, 8'h11); flush = 1'b1;
    step(); idle();
    chk("flush_count", 32'(b1_count), 32'h0);
    rd(0, 3'd1);
    step(); idle();
    chk("flush_rd_err",  32'(b1_rd_err[0]),     32'h1);
    chk("flush_rd_data", 32'(b1_rd_data[7:0]),  32'h00);

    // Write plus invalidate to the same entry: write wins.
    wr(3'd6, 8'h66); inv_en = 1'b1; inv_addr = 3'd6;
    step(); idle();
    chk("wrinv_count", 32'(b1_count), 32'h1);
    chk("wrinv_d6_wrerr", 32'(d6_wr_err), 32'h1);
    chk("wrinv_d6_count", 32'(d6_count), 32'h0);
    rd(0, 3'd6);
    step(); idle();
    e = '{data: 8'h66, valid: 1'b1, err: 1'b0};
    chk_b1_port("wrinv_rd", 0, e);
    chk("d6_wrerr_clear", 32'(d6_wr_err), 32'h0);

    // Rewriting a valid entry does not increment count.
    wr(3'd6, 8'h67);
    step(); idle();
    chk("rewr_count", 32'(b1_count), 32'h1);

    // DEPTH=6: out-of-range write to addr 7.
    wr(3'd7, 8'h77);
    step(); idle();
    chk("oor_d6_wrerr", 32'(d6_wr_err), 32'h1);
    chk("oor_d6_count", 32'(d6_count),  32'h0);
    chk("oor_b1_wrerr", 32'(b1_wr_err), 32'h0);
    chk("oor_b1_count", 32'(b1_count),  32'h2);
    rd(0, 3'd7);
    step(); idle();
    chk("oor_d6_pulse_end", 32'(d6_wr_err),      32'h0);
    chk("oor_d6_rd_valid",  32'(d6_rd_valid[0]), 32'h1);
    chk("oor_d6_rd_err",    32'(d6_rd_err[0]),   32'h1);
    chk("oor_d6_rd_data",   32'(d6_rd_data[7:0]), 32'h00);
    chk("oor_b1_rd_data",   32'(b1_rd_data[7:0]), 32'h77);

    // Out-of-range write and invalidate together: one single-cycle pulse.
    wr(3'd7, 8'h01); inv_en = 1'b1; inv_addr = 3'd6;
    step(); idle();
    chk("dual_d6_wrerr", 32'(d6_wr_err), 32'h1);
    step();
    chk("dual_d6_wrerr_end", 32'(d6_wr_err), 32'h0);

    // Reset with a read pending: no response afterwards.
    resetn = 1'b0; rd(0, 3'd2); rd(1, 3'd6);
    step(); idle();
    resetn = 1'b1;
    chk("rstrd_valid", 32'(b1_rd_valid), 32'h0);
    chk("rstrd_count", 32'(b1_count),    32'h0);
    step();
    chk("rstrd_valid2", 32'(b1_rd_valid), 32'h0);
    chk("rstrd_data2",  32'(b1_rd_data),  32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ff_regfile_mp.md
Name: ff_regfile_mp

Overview:
- Parametrised flip-flop register file with per-entry valid tracking.
- One write port, an invalidate port, a global flush, and RD_PORTS independent registered read ports.
- Reports read-of-unwritten and out-of-range errors per port, and a live occupancy count.
- Used as small metadata/tag storage where entries must be explicitly retired; successor to the single-port valid-tracked flip-flop array.

Parameters:
- DATA_W, 8: entry width in bits.
- ADDR_W, 3: address width.
- DEPTH, 8: number of entries; legal range 2 to 2**ADDR_W. Addresses >= DEPTH are out of range.
- RD_PORTS, 2: number of read ports, 1 to 4.
- BYPASS, 1: 1 = a read returns same-cycle write data (write-through); 0 = a read returns pre-write state.

Ports:
- clk  in  1  clock, all logic on rising edge
- resetn  in  1  synchronous, active-low reset
- wr_en  in  1  write strobe
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- inv_en  in  1  invalidate strobe
- inv_addr  in  ADDR_W  entry to invalidate
- flush  in  1  clear all valid bits
- rd_en  in  RD_PORTS  per-port read strobe
- rd_addr  in  RD_PORTS*ADDR_W  packed read addresses; port p uses bits [p*ADDR_W +: ADDR_W]
- rd_data  out  RD_PORTS*DATA_W  packed registered read data
- rd_valid  out  RD_PORTS  read response strobe
- rd_err  out  RD_PORTS  read hit an invalid or out-of-range entry
- wr_err  out  1  registered pulse: write or invalidate to an out-of-range address
- count  out  $clog2(DEPTH+1)  number of valid entries

Behaviour:
- Reset (resetn=0 at a clock edge):
  - Valid vector, rd_data, rd_valid, rd_err, wr_err and count all go to 0.
  - The data array is not reset.
  - A read issued in the reset cycle produces no response.
- Write: wr_en with in-range wr_addr stores wr_data and sets valid at the next edge.
- Invalidate: inv_en with in-range inv_addr clears that entry's valid bit; data is retained.
- Flush: clears every valid bit at the next edge.
- Priority for same-cycle events on an entry's valid bit: flush > write > invalidate.
  - Write plus invalidate to the same address: entry ends valid with new data.
  - Write plus flush: data is stored, entry ends invalid.
- Out-of-range write or invalidate: no state change; wr_err=1 for exactly the next cycle. Both in one cycle still give a single wr_err pulse.
- Read latency is 1 cycle. rd_en[p] at edge N gives rd_valid[p]=1 during cycle N+1.
  - rd_valid[p]=0 in any cycle not following rd_en[p].
  - While rd_valid[p]=0, rd_data[p] and rd_err[p] are 0.
- Read result, evaluated on the state before edge N:
  - Entry valid: rd_data = stored data, rd_err=0.
  - Entry invalid or address out of range: rd_data=0, rd_err=1.
  - BYPASS=1 and in-range wr_en to the same address in the same cycle: rd_data=wr_data, rd_err=0, regardless of prior valid.
  - BYPASS=0: a same-cycle write is not visible to the read.
  - Same-cycle invalidate or flush does not affect the read; the read sees pre-clear state.
- Multiple read ports may read the same address in the same cycle; all return identical results.
- count is a registered popcount of the next-state valid vector, so it always matches the valid bits in the same cycle.
  - Range is 0..DEPTH.
  - Writing an already-valid entry does not increment it.
  - Invalidating an already-invalid entry does not decrement it.
- The write path has no error for simultaneous rd_en and wr_en. Concurrent read and write is legal.

Decomposition:
- Shared package ff_regfile_pkg:
  - function clog2_cnt(depth)
  - typedef rd_rsp_t {data, valid, err} parametrised via DATA_W localparam
- Sub-module ff_regfile_rd_port, instantiated RD_PORTS times in a generate loop:
  - inputs: entry array, valid vector, write-bypass signals, rd_en, rd_addr
  - contains the address-range check, bypass mux and output register

Test Plan:
- Reset, then read addr 3 on port 0 -> next cycle rd_valid[0]=1, rd_err[0]=1, rd_data[0]=0x00, count=0.
- Write 0xA5 to addr 2, next cycle read addr 2 on ports 0 and 1 -> both rd_data=0xA5, rd_err=0; count=1.
- Same-cycle write 0x3C to addr 5 and read addr 5:
  - BYPASS=1 -> rd_data=0x3C, rd_err=0.
  - BYPASS=0 -> rd_data=0x00, rd_err=1.
  - Following-cycle read returns 0x3C in both cases.
- Fill addrs 0..7 (count=8), then invalidate addr 4 with a same-cycle read of addr 4 -> read returns old data with rd_err=0; count=7; subsequent read of addr 4 gives rd_err=1.
- Write 0x11 to addr 1 plus flush in the same cycle -> count=0; read addr 1 next cycle gives rd_err=1. Write plus invalidate to addr 6 -> entry valid, count=1.
- DEPTH=6: write to addr 7 -> wr_err pulses 1 cycle, count unchanged; read addr 7 -> rd_err=1. Assert resetn=0 with a read pending -> no rd_valid the following cycle.
